// File: rtl/paddle_move_scheduler.sv
// Round-robin delay-timer arbiter and saturating position keeper for two pong paddles.
// Define PADDLE_SCHED_FIXED_PRIORITY_EN to make paddle 0 always win simultaneous requests.
module paddle_move_scheduler #(
    parameter int unsigned DELAY_CYCLES = 500000,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned Y_W          = 10,
    parameter int unsigned STEP         = 4,
    parameter int unsigned Y_MIN        = 0,
    parameter int unsigned Y_MAX        = 400,
    parameter int unsigned Y_RESET      = 200
) (
    input  logic           CLK_100MHz,
    input  logic           Reset,
    input  logic [1:0]     delay_req,
    input  logic [1:0]     moveUp,
    input  logic [1:0]     moveDown,
    output logic [1:0]     done,
    output logic           grant,
    output logic           busy,
    output logic [Y_W-1:0] paddle_y0,
    output logic [Y_W-1:0] paddle_y1
);

    localparam int unsigned      YW1     = Y_W + 1;
    localparam logic [CNT_W-1:0] C_LOAD  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [YW1-1:0]   C_STEP  = YW1'(STEP);
    localparam logic [YW1-1:0]   C_MIN   = YW1'(Y_MIN);
    localparam logic [YW1-1:0]   C_MAX   = YW1'(Y_MAX);
    localparam logic [Y_W-1:0]   C_RESET = Y_W'(Y_RESET);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_grant;
    logic             w_grant_nxt;
    logic [1:0]       r_done;
    logic [1:0]       w_done_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [Y_W-1:0]   r_y0;
    logic [Y_W-1:0]   r_y1;
    logic [Y_W-1:0]   w_y0_nxt;
    logic [Y_W-1:0]   w_y1_nxt;
    logic             w_winner;
    logic [Y_W-1:0]   w_y_cur;
    logic [YW1-1:0]   w_y_ext;
    logic [YW1-1:0]   w_y_dec;
    logic [YW1-1:0]   w_y_inc;
    logic             w_up;
    logic             w_dn;
    logic [Y_W-1:0]   w_y_moved;

`ifdef PADDLE_SCHED_FIXED_PRIORITY_EN
    // Paddle 1 only wins when paddle 0 is not requesting.
    assign w_winner = ~delay_req[0];
`else
    logic r_rr;
    logic w_rr_nxt;

    assign w_winner = (&delay_req) ? r_rr : delay_req[1];
`endif

    // Saturating step for the granted paddle; extra bit exposes borrow/carry.
    always_comb begin
        w_y_cur   = r_grant ? r_y1 : r_y0;
        w_up      = moveUp[r_grant];
        w_dn      = moveDown[r_grant];
        w_y_ext   = {1'b0, w_y_cur};
        w_y_dec   = w_y_ext - C_STEP;
        w_y_inc   = w_y_ext + C_STEP;
        w_y_moved = w_y_cur;
        if (w_up && !w_dn) begin
            w_y_moved = (w_y_dec[Y_W] || (w_y_dec < C_MIN)) ? C_MIN[Y_W-1:0] : w_y_dec[Y_W-1:0];
        end else if (w_dn && !w_up) begin
            w_y_moved = (w_y_inc > C_MAX) ? C_MAX[Y_W-1:0] : w_y_inc[Y_W-1:0];
        end
    end

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_grant <= 1'b0;
            r_done  <= 2'b00;
            r_busy  <= 1'b0;
            r_y0    <= C_RESET;
            r_y1    <= C_RESET;
`ifndef PADDLE_SCHED_FIXED_PRIORITY_EN
            r_rr    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            r_y0    <= w_y0_nxt;
            r_y1    <= w_y1_nxt;
`ifndef PADDLE_SCHED_FIXED_PRIORITY_EN
            r_rr    <= w_rr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|delay_req) w_state_nxt = S_COUNT;
            S_COUNT: if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_done_nxt  = 2'b00;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_y0_nxt    = r_y0;
        w_y1_nxt    = r_y1;
`ifndef PADDLE_SCHED_FIXED_PRIORITY_EN
        w_rr_nxt    = r_rr;
`endif
        case (r_state)
            S_IDLE: begin
                if (|delay_req) begin
                    w_grant_nxt = w_winner;
                    w_cnt_nxt   = C_LOAD;
                end
            end
            S_COUNT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_done_nxt = r_grant ? 2'b10 : 2'b01;
                end
            end
            S_DONE: begin
`ifndef PADDLE_SCHED_FIXED_PRIORITY_EN
                w_rr_nxt = ~r_grant;
`endif
                if (r_grant) begin
                    w_y1_nxt = w_y_moved;
                end else begin
                    w_y0_nxt = w_y_moved;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    assign done      = r_done;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign paddle_y0 = r_y0;
    assign paddle_y1 = r_y1;

endmodule

// File: tb/tb_paddle_move_scheduler.sv
// Scoreboard bench for paddle_move_scheduler: a transaction-level model predicts each grant,
// its done cycle and the resulting positions; a monitor checks every done pulse against it.
module tb_paddle_move_scheduler;

    localparam int D     = 8;
    localparam int STEPI = 4;
    localparam int YMAX  = 400;
    localparam int YRST  = 200;
    localparam int YW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    delay_req;
    logic [1:0]    move_up;
    logic [1:0]    move_dn;
    logic [1:0]    done;
    logic          grant;
    logic          busy;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;

    paddle_move_scheduler #(
        .DELAY_CYCLES(D), .CNT_W(4), .Y_W(YW), .STEP(STEPI),
        .Y_MIN(0), .Y_MAX(YMAX), .Y_RESET(YRST)
    ) dut (
        .CLK_100MHz(clk), .Reset(rst), .delay_req(delay_req),
        .moveUp(move_up), .moveDown(move_dn), .done(done),
        .grant(grant), .busy(busy), .paddle_y0(y0), .paddle_y1(y1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int paddle;
        int y0;
        int y1;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_y[2];
    int   m_rr;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y[0] = YRST;
        m_y[1] = YRST;
        m_rr   = 0;
        q.delete();
    endtask

    // Arbitrate, step and record the expected outcome of one grant.
    task automatic model_grant(input logic [1:0] req, input logic [1:0] up,
                               input logic [1:0] dn, input int exp_cyc);
        int   w;
        exp_t e;
`ifdef PADDLE_SCHED_FIXED_PRIORITY_EN
        w = req[0] ? 0 : 1;
`else
        if (req == 2'b11) w = m_rr;
        else              w = req[1] ? 1 : 0;
`endif
        m_rr = 1 - w;
        if (up[w] && !dn[w])      m_y[w] = (m_y[w] - STEPI < 0) ? 0 : m_y[w] - STEPI;
        else if (dn[w] && !up[w]) m_y[w] = (m_y[w] + STEPI > YMAX) ? YMAX : m_y[w] + STEPI;
        e.paddle = w;
        e.y0     = m_y[0];
        e.y1     = m_y[1];
        e.cyc    = exp_cyc;
        q.push_back(e);
    endtask

    // One arbitration round; called and returns on a falling edge with the DUT idle.
    task automatic round(input logic [1:0] req, input logic [1:0] up,
                         input logic [1:0] dn, input bit drop);
        delay_req = req;
        move_up   = up;
        move_dn   = dn;
        if (req == 2'b00) begin
            @(negedge clk);
            return;
        end
        model_grant(req, up, dn, cyc + 1 + D);
        for (int i = 0; i < D + 2; i++) begin
            @(negedge clk);
            if (drop && i == 3) delay_req = 2'b00;
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    exp_t pend;
    bit   chk_y = 1'b0;
    always @(negedge clk) begin
        if (chk_y) begin
            chk("y0_after_done", int'(y0), pend.y0);
            chk("y1_after_done", int'(y1), pend.y1);
            chk_y = 1'b0;
        end
        if (done !== 2'b00) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=%b expected none (t=%0t)", done, $time);
            end else begin
                pend = q.pop_front();
                chk("done_vec", int'(done), 1 << pend.paddle);
                chk("grant_idx", int'(grant), pend.paddle);
                chk("done_cycle", cyc, pend.cyc);
                chk("busy_in_done", int'(busy), 1);
                chk_y = 1'b1;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        delay_req = 2'b00;
        move_up   = 2'b00;
        move_dn   = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_y0", int'(y0), YRST);
        chk("rst_y1", int'(y1), YRST);
        rst = 1'b0;
        @(negedge clk);

        // Single up move on paddle 0.
        round(2'b01, 2'b01, 2'b00, 1'b0);
        chk("single_up_y0", int'(y0), 196);
        chk("single_up_y1", int'(y1), 200);

        // Simultaneous requests, both moving down.
        repeat (3) round(2'b11, 2'b00, 2'b11, 1'b0);

        // Both and neither move bits: position holds, done still pulses.
        round(2'b01, 2'b01, 2'b01, 1'b0);
        round(2'b10, 2'b00, 2'b00, 1'b0);
        round(2'b10, 2'b10, 2'b10, 1'b1);

        // Randomized rounds, some dropping the request mid-countdown.
        for (int i = 0; i < 60; i++) begin
            round(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        // Saturation at both bounds.
        repeat (105) round(2'b01, 2'b01, 2'b00, 1'b0);
        chk("y0_sat_min", int'(y0), 0);
        repeat (105) round(2'b10, 2'b00, 2'b10, 1'b0);
        chk("y1_sat_max", int'(y1), YMAX);

        // Reset mid-count: grant paddle 0 so rr points at 1, then abort a paddle 1 grant.
        round(2'b01, 2'b00, 2'b01, 1'b0);
        delay_req = 2'b10;
        move_up   = 2'b10;
        move_dn   = 2'b00;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_y0", int'(y0), YRST);
        chk("midrst_y1", int'(y1), YRST);
        model_reset();
        delay_req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        repeat (D + 4) @(negedge clk);
        round(2'b11, 2'b01, 2'b00, 1'b0);
        round(2'b11, 2'b00, 2'b10, 1'b0);

        delay_req = 2'b00;
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
